// File: rtl/onchip_mem_tester.sv
// Avalon-MM self-test master for a single-port on-chip memory: writes an address-derived
// pattern over a word range, reads it back pipelined, then repeats with the complement.
module onchip_mem_tester #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  input  logic [ADDR_W-1:0]   first_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   fail_addr,
  output logic [DATA_W-1:0]   fail_data,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic                m_clken,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic [2:0]          dbg_state
);

  // Bus handshake: the slave has no waitrequest, so every cycle with m_chipselect=1 is
  // one accepted transfer; read data returns exactly READ_LATENCY cycles after its address.

  localparam int HALF  = DATA_W / 2;
  localparam int L     = READ_LATENCY;
  localparam int CNT_W = $clog2(L + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR0, S_RD0, S_DR0, S_WR1, S_RD1, S_DR1, S_DONE
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   seed_q;
  logic [ADDR_W-1:0]   first_q;
  logic [ADDR_W-1:0]   last_q;
  logic                inv_q;
  logic [CNT_W-1:0]    drain_cnt;

  logic                pv [L];
  logic [ADDR_W-1:0]   pa [L];
  logic [DATA_W-1:0]   pd [L];

  logic [ADDR_W-1:0]   addr_next;
  logic                at_last;
  logic                reading;
  logic                mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] s,
                                                input logic inv);
    logic [HALF-1:0] h;
    h = HALF'(a);
    return ({h, ~h} ^ s) ^ {DATA_W{inv}};
  endfunction

  assign addr_next = m_address + ADDR_W'(1);
  assign at_last   = (m_address == last_q);
  assign reading   = (state == S_RD0) || (state == S_RD1);
  assign mismatch  = pv[L-1] && (m_readdata != pd[L-1]);
  assign pass      = done && (err_count == '0);
  assign dbg_state = state;

  // Read-compare pipe: stage 0 is loaded on the edge that closes a read cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= reading;
      pa[0] <= m_address;
      pd[0] <= pattern(m_address, seed_q, inv_q);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      seed_q       <= '0;
      first_q      <= '0;
      last_q       <= '0;
      inv_q        <= 1'b0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_count    <= '0;
      fail_addr    <= '0;
      fail_data    <= '0;
      m_address    <= '0;
      m_byteenable <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_clken      <= 1'b1;
      m_writedata  <= '0;
    end else begin
      m_clken <= 1'b1;

      // err_count never returns to zero once bumped, so zero means "no mismatch yet".
      if (mismatch) begin
        if (err_count != '1)
          err_count <= err_count + ERR_W'(1);
        if (err_count == '0) begin
          fail_addr <= pa[L-1];
          fail_data <= m_readdata;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seed_q    <= seed;
            first_q   <= first_addr;
            last_q    <= last_addr;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            done      <= 1'b0;
            inv_q     <= 1'b0;
            if (first_addr > last_addr) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state        <= S_WR0;
              busy         <= 1'b1;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_byteenable <= '1;
              m_address    <= first_addr;
              m_writedata  <= pattern(first_addr, seed, 1'b0);
            end
          end
        end

        S_WR0, S_WR1: begin
          if (at_last) begin
            state     <= (state == S_WR0) ? S_RD0 : S_RD1;
            m_write   <= 1'b0;
            m_address <= first_q;
          end else begin
            m_address   <= addr_next;
            m_writedata <= pattern(addr_next, seed_q, inv_q);
          end
        end

        S_RD0, S_RD1: begin
          if (at_last) begin
            state        <= (state == S_RD0) ? S_DR0 : S_DR1;
            m_chipselect <= 1'b0;
            drain_cnt    <= '0;
          end else begin
            m_address <= addr_next;
          end
        end

        S_DR0, S_DR1: begin
          if (drain_cnt == CNT_W'(L - 1)) begin
            if (state == S_DR0) begin
              state        <= S_WR1;
              inv_q        <= 1'b1;
              m_chipselect <= 1'b1;
              m_write      <= 1'b1;
              m_address    <= first_q;
              m_writedata  <= pattern(first_q, seed_q, 1'b1);
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_tester.md
# onchip_mem_tester

Avalon-MM master that drives the single-port on-chip memory slave (32-bit data, 15-bit word address, byte enables, clock enable, fixed read latency) from the far end of the interface. On `start` it writes a seeded address-derived pattern over a programmed word range, reads it back pipelined, then repeats with the complemented pattern. It reports pass/fail, a saturating error count and the first failing location. It sits beside the memory on the QSYS fabric, or directly on the slave port, as a power-on/bring-up self-test.

## Interface
- `ADDR_W`, 15, word-address width
- `DATA_W`, 32, data width (multiple of 8)
- `READ_LATENCY`, 1, cycles from read address presented to `m_readdata` valid (≥1)
- `ERR_W`, 16, error-counter width
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE/DONE
- `seed`  in  DATA_W  pattern XOR seed, latched at start
- `first_addr`, `last_addr`  in  ADDR_W  inclusive word range, latched at start
- `busy`  out  1  test in progress
- `done`  out  1  test finished; held until next accepted start
- `pass`  out  1  `done` and `err_count==0`
- `err_count`  out  ERR_W  mismatching reads, saturating
- `fail_addr`  out  ADDR_W  address of first mismatch
- `fail_data`  out  DATA_W  data read at first mismatch
- `m_address`  out  ADDR_W; `m_byteenable` out DATA_W/8; `m_chipselect`, `m_write`, `m_clken` out 1; `m_writedata` out DATA_W; `m_readdata` in DATA_W

## Operation
- Pattern: P(a) = {zero-extended a in upper half, its bitwise complement in lower half} XOR seed; pass 1 writes/expects P(a), pass 2 writes/expects ~P(a).
- States: IDLE → WR0 → RD0 → DR0 → WR1 → RD1 → DR1 → DONE.
- IDLE/DONE + `start`: latch seed/range, clear `err_count`, `fail_*`, `done`; go to WR0. If `first_addr > last_addr` go straight to DONE (empty range, `pass`=1, no bus activity).
- WRn: one write per cycle, `m_chipselect`=`m_write`=1, `m_byteenable`=all ones, address first→last; leave after last_addr.
- RDn: one read per cycle (`m_write`=0, `m_chipselect`=1), address first→last; address and expected data pushed into a READ_LATENCY-deep shift pipe.
- DRn: READ_LATENCY cycles, no bus access (`m_chipselect`=0), pipe drains; compares continue.
- Compare: when pipe output valid, `m_readdata` ≠ expected → `err_count`+1 (hold at all ones); if first mismatch of this test, capture `fail_addr`, `fail_data`.
- Address counter compares against last_addr before increment; `last_addr` = 2^ADDR_W−1 must not wrap to 0 or overrun.
- `start` while busy ignored. `m_clken` = 1 always out of reset.

## Timing
- Reset (async, immediate): state IDLE; `busy`,`done`,`pass`,`m_chipselect`,`m_write`=0; `m_clken`=1; `m_byteenable`=0; `m_address`,`m_writedata`,`err_count`,`fail_addr`,`fail_data`=0; pipe valids cleared. Reset mid-test aborts with no further bus cycles after deassert.
- `start` sampled at edge k → first write on bus and `busy`=1 in cycle k+1.
- N = last−first+1, L = READ_LATENCY: bus busy 4N cycles, drains 2L; `done`=1, `busy`=0 exactly 4N+2L+1 cycles after edge k.
- Empty range: `done`=1 at cycle k+1, `busy` never asserted.
- Read issued in cycle t compared in cycle t+L; last compare of each pass lands in final drain cycle.
- `pass`, `err_count`, `fail_*` stable whenever `done`=1.

## Test plan
- Ideal memory model, seed 0xA5A5_0000, range 0x0010–0x0013, L=1 → write data at 0x0010 = 0x0010_FFEF^seed, `done` 19 cycles after start, `pass`=1, `err_count`=0.
- Model with bit 3 stuck-at-1 at address 0x0012 only, range 0x0010–0x001F → `err_count`=1 (only the pass whose expected bit 3 is 0 fails), `fail_addr`=0x0012, `fail_data` = expected|0x8, `pass`=0.
- Full range 0x0000–0x7FFF, L=1 → `done` after 131075 cycles, no address above 0x7FFF or wrap to 0 inside a phase, `pass`=1.
- `first_addr`=5, `last_addr`=4 → `done`=`pass`=1 next cycle, `m_chipselect` never high.
- Every location faulty, ERR_W=4, range 0–31 → `err_count` saturates at 15, `fail_addr`=0.
- `reset_n` low mid-RD0 → outputs reset asynchronously; second `start` mid-test ignored; fresh start after reset passes; READ_LATENCY=2 run passes with `done` at 4N+5.
